spi_frame_receiver: RTL and testbench
=====================================

// Module: spi_frame_receiver
// PURPOSE
//  Host-side receiver for the camera frame link: consumes the byte stream from an SPI master
//  core, parses the 3-byte length header (LEN[15:8], LEN[7:0], 0x00), then writes LEN+1 payload
//  bytes into the host frame buffer at addresses 0..LEN. Tracks the JPEG EOI marker (FF D9),
//  flags framing errors and times out stalled transfers. Sits between SPI master and frame RAM.
// PARAMETERS
//  ADDR_W          16        frame buffer address width; LEN is ADDR_W bits
//  TIMEOUT_CYCLES  100000    max clk cycles between rx_valid pulses inside a frame
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  reset        in   1       asynchronous, active-low; clears all state
//  start        in   1       1-cycle pulse: arm receiver for next frame (ignored unless IDLE)
//  abort        in   1       synchronous: return to IDLE, no frame_done
//  rx_data      in   8       byte from SPI master core
//  rx_valid     in   1       1-cycle strobe, rx_data valid; never back-pressured
//  wr_addr      out  ADDR_W  frame buffer write address
//  wr_data      out  8       frame buffer write data
//  wr_en        out  1       frame buffer write strobe
//  busy         out  1       high in any state except IDLE
//  frame_len    out  ADDR_W  latched LEN (last address) of current/last frame
//  frame_done   out  1       1-cycle pulse, frame completed (with or without errors)
//  eoi_ok       out  1       last two payload bytes were FF D9; valid from frame_done until next start
//  err_pad      out  1       sticky: header byte 2 != 0x00
//  err_timeout  out  1       sticky: inter-byte gap exceeded TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. start clears err_*, eoi_ok, frame_len.
//  FSM: IDLE -start-> HDR_HI -rx-> HDR_LO -rx-> HDR_PAD -rx-> DATA -rx of byte LEN-> IDLE.
//   - HDR_HI: latch rx_data into frame_len[15:8]; HDR_LO: frame_len[7:0].
//   - HDR_PAD: rx_data != 0x00 sets err_pad; frame still proceeds (data length trusted).
//   - DATA: each rx_valid -> next cycle wr_en=1, wr_data=rx_data, wr_addr=byte index (0-based);
//     index increments after each write; latency rx_valid->wr_en exactly 1 cycle.
//   - Final byte (index==frame_len): wr_en and frame_done asserted in the same cycle; FSM IDLE.
//  LEN=0: exactly one payload byte at address 0. LEN=max (all ones): index compare, no wrap.
//  EOI: 2-byte shift register of payload bytes; eoi_ok = (prev==0xFF && last==0xD9) at final byte;
//   LEN=0 -> eoi_ok=0. FF D9 earlier in payload does NOT end the frame.
//  Timeout: counter cleared on each rx_valid and on entry to HDR_HI; counts in non-IDLE states;
//   reaching TIMEOUT_CYCLES -> err_timeout=1, frame_done pulse, IDLE, no further writes.
//  rx_valid in IDLE: ignored, no write. rx_valid same cycle as start: byte ignored.
//  start while busy: ignored. abort has priority over rx_valid and timeout in the same cycle;
//   abort in IDLE is a no-op. Async reset mid-frame: immediate IDLE, wr_en drops same instant.
//  wr_addr/wr_data hold last values when wr_en=0.
// STRUCTURE
//  Package spi_frame_pkg: FSM state localparams (IDLE, HDR_HI, HDR_LO, HDR_PAD, DATA),
//   HDR_PAD_BYTE=8'h00, EOI_HI=8'hFF, EOI_LO=8'hD9, header length 3 (shared with transmitter).
//  Sub-module spi_eoi_tracker: 2-byte shift reg + compare, clear on start, shift on payload write.
//  Top holds FSM, byte index counter, timeout counter, output registers.
// TESTING
//  1 start; bytes 00 03 00 AA FF FF D9 -> writes A0..A3 = AA FF FF D9, frame_done with 4th write, eoi_ok=1.
//  2 header 00 00 00, byte 5A -> one write addr 0 =5A, frame_done, eoi_ok=0, frame_len=0.
//  3 header 00 01 7E, bytes 11 22 -> err_pad=1, both written, frame_done, eoi_ok=0.
//  4 TIMEOUT_CYCLES=16: header 00 09 00, 2 bytes, then idle 16 cycles -> err_timeout=1, frame_done, no more wr_en.
//  5 rx_valid bytes in IDLE and start+rx_valid same cycle -> no wr_en; next header parsed normally.
//  6 abort mid-DATA coincident with rx_valid -> no write that cycle, busy=0, no frame_done; reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared constants and FSM state type for the camera frame link (receiver and transmitter).
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_HDR_PAD = 3'd3,
    ST_DATA    = 3'd4
  } state_e;

  localparam logic [7:0]  HDR_PAD_BYTE = 8'h00;
  localparam logic [7:0]  EOI_HI       = 8'hFF;
  localparam logic [7:0]  EOI_LO       = 8'hD9;
  localparam int unsigned HDR_LEN      = 3;

endpackage

// File: rtl/spi_eoi_tracker.sv
// Tracks the JPEG EOI marker (FF D9) across the payload bytes written to the frame buffer.
module spi_eoi_tracker
  import spi_frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic       match_o
);

  logic [7:0] last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (clear_i) begin
      last_q <= '0;
    end else if (shift_i) begin
      last_q <= data_i;
    end
  end

  // Window is {previous byte, incoming byte}, so the verdict is ready on the final write itself.
  assign match_o = (last_q == EOI_HI) && (data_i == EOI_LO);

endmodule

// File: rtl/spi_frame_receiver.sv
// Host-side frame receiver: parses the 3-byte length header and writes LEN+1 payload bytes to the frame buffer.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic [ADDR_W-1:0] frame_len,
  output logic              frame_done,
  output logic              eoi_ok,
  output logic              err_pad,
  output logic              err_timeout
);

  localparam int unsigned        TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [7:0]          wr_data_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   frame_len_q;
  logic                frame_done_q;
  logic                eoi_ok_q;
  logic                err_pad_q;
  logic                err_timeout_q;

  logic                aborting;
  logic                eoi_clear;
  logic                eoi_shift;
  logic                eoi_match;
  logic [ADDR_W-1:0]   idx_d;

  assign aborting  = abort && (state_q != ST_IDLE);
  assign eoi_clear = (state_q == ST_IDLE) && start;
  assign eoi_shift = (state_q == ST_DATA) && rx_valid && !abort;
  assign idx_d     = idx_q + ADDR_W'(1);

  spi_eoi_tracker u_eoi (
    .clk     (clk),
    .reset   (reset),
    .clear_i (eoi_clear),
    .shift_i (eoi_shift),
    .data_i  (rx_data),
    .match_o (eoi_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      to_cnt_q      <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      frame_len_q   <= '0;
      frame_done_q  <= 1'b0;
      eoi_ok_q      <= 1'b0;
      err_pad_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (aborting) begin
        state_q  <= ST_IDLE;
        to_cnt_q <= '0;
      end else if (state_q == ST_IDLE) begin
        if (start) begin
          state_q       <= ST_HDR_HI;
          idx_q         <= '0;
          to_cnt_q      <= '0;
          frame_len_q   <= '0;
          eoi_ok_q      <= 1'b0;
          err_pad_q     <= 1'b0;
          err_timeout_q <= 1'b0;
        end
      end else if (rx_valid) begin
        to_cnt_q <= '0;
        unique case (state_q)
          ST_HDR_HI: begin
            frame_len_q <= ADDR_W'({rx_data, 8'h00});
            state_q     <= ST_HDR_LO;
          end
          ST_HDR_LO: begin
            frame_len_q <= frame_len_q | ADDR_W'(rx_data);
            state_q     <= ST_HDR_PAD;
          end
          ST_HDR_PAD: begin
            if (rx_data != HDR_PAD_BYTE) begin
              err_pad_q <= 1'b1;
            end
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= rx_data;
            // Equality on the index (not a wrapped count) so LEN = all-ones still terminates.
            if (idx_q == frame_len_q) begin
              frame_done_q <= 1'b1;
              eoi_ok_q     <= eoi_match;
              state_q      <= ST_IDLE;
            end else begin
              idx_q <= idx_d;
            end
          end
          default: ;
        endcase
      end else if (to_cnt_q == TO_LAST) begin
        err_timeout_q <= 1'b1;
        frame_done_q  <= 1'b1;
        to_cnt_q      <= '0;
        state_q       <= ST_IDLE;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en       = wr_en_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_len   = frame_len_q;
  assign frame_done  = frame_done_q;
  assign eoi_ok      = eoi_ok_q;
  assign err_pad     = err_pad_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a write scoreboard.
module tb_spi_frame_receiver;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic [15:0] frame_len;
  logic        frame_done;
  logic        eoi_ok;
  logic        err_pad;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic        last;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  spi_frame_receiver #(.ADDR_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .frame_len   (frame_len),
    .frame_done  (frame_done),
    .eoi_ok      (eoi_ok),
    .err_pad     (err_pad),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [15:0] addr, input logic [7:0] b, input logic last);
    exp_q.push_back('{last: last, addr: addr, data: b});
    send_byte(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] pad);
    send_byte(hi);
    send_byte(lo);
    send_byte(pad);
  endtask

  // Scoreboard: every write must match the oldest expected entry; frame_done must coincide with the last one.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_done) done_cnt++;
      if (wr_en) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", wr_addr, wr_data);
        end
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
          check("done_with_write", 32'(frame_done), 32'(mon_e.last));
        end
      end
    end
  end

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_flags", {28'd0, frame_done, eoi_ok, err_pad, err_timeout}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: four-byte frame ending in EOI
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_header(8'h00, 8'h03, 8'h00);
    check("t1_frame_len", 32'(frame_len), 32'd3);
    send_payload(16'd0, 8'hAA, 1'b0);
    send_payload(16'd1, 8'hFF, 1'b0);
    send_payload(16'd2, 8'hFF, 1'b0);
    send_payload(16'd3, 8'hD9, 1'b1);
    tick();
    check("t1_eoi_ok", 32'(eoi_ok), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2: LEN=0, single byte
    pulse_start();
    check("t2_eoi_cleared", 32'(eoi_ok), 32'd0);
    send_header(8'h00, 8'h00, 8'h00);
    send_payload(16'd0, 8'h5A, 1'b1);
    tick();
    check("t2_eoi_ok", 32'(eoi_ok), 32'd0);
    check("t2_frame_len", 32'(frame_len), 32'd0);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // 3: bad pad byte, frame still received
    pulse_start();
    send_header(8'h00, 8'h01, 8'h7E);
    check("t3_err_pad", 32'(err_pad), 32'd1);
    send_payload(16'd0, 8'h11, 1'b0);
    send_payload(16'd1, 8'h22, 1'b1);
    tick();
    check("t3_eoi_ok", 32'(eoi_ok), 32'd0);
    check("t3_done_cnt", 32'(done_cnt), 32'd3);

    // 4: stall after two bytes -> timeout after 16 idle cycles
    pulse_start();
    check("t4_err_pad_cleared", 32'(err_pad), 32'd0);
    send_header(8'h00, 8'h09, 8'h00);
    send_payload(16'd0, 8'h01, 1'b0);
    send_payload(16'd1, 8'h02, 1'b0);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (frame_done) begin
        n = i;
        break;
      end
    end
    check("t4_timeout_cycles", 32'(n), 32'd16);
    check("t4_err_timeout", 32'(err_timeout), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("t4_done_cnt", 32'(done_cnt), 32'd4);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: bytes in IDLE and start coincident with rx_valid are ignored
    send_byte(8'h55);
    send_byte(8'h66);
    start    = 1'b1;
    rx_data  = 8'h07;
    rx_valid = 1'b1;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    check("t5_err_timeout_cleared", 32'(err_timeout), 32'd0);
    check("t5_frame_len_cleared", 32'(frame_len), 32'd0);
    send_header(8'h00, 8'h01, 8'h00);
    send_payload(16'd0, 8'h33, 1'b0);
    send_payload(16'd1, 8'h44, 1'b1);
    tick();
    check("t5_frame_len", 32'(frame_len), 32'd1);
    check("t5_done_cnt", 32'(done_cnt), 32'd5);

    // 6: abort coincident with rx_valid, then async reset mid-frame
    pulse_start();
    send_header(8'h00, 8'h05, 8'h00);
    send_payload(16'd0, 8'h10, 1'b0);
    send_payload(16'd1, 8'h20, 1'b0);
    abort    = 1'b1;
    rx_data  = 8'h30;
    rx_valid = 1'b1;
    tick();
    abort    = 1'b0;
    rx_valid = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_wr_en", 32'(wr_en), 32'd0);
    repeat (3) tick();
    check("t6_abort_no_done", 32'(done_cnt), 32'd5);

    pulse_start();
    send_header(8'h00, 8'h05, 8'h00);
    send_payload(16'd0, 8'h01, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_wr_en", 32'(wr_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_frame_len", 32'(frame_len), 32'd0);
    check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("t6_rst_wr_data", 32'(wr_data), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Post-reset frame: lone D9 must not be reported as EOI
    pulse_start();
    send_header(8'h00, 8'h00, 8'h00);
    send_payload(16'd0, 8'hD9, 1'b1);
    tick();
    check("t7_eoi_ok", 32'(eoi_ok), 32'd0);
    check("t7_done_cnt", 32'(done_cnt), 32'd6);
    check("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
